execute_stage_md: RTL and testbench

EXECUTE_STAGE_MD -- requirements
Module: execute_stage_md

---
 rtl/execute_stage_md.sv | 278 +++++++++++++++++++++++++++
 tb/tb_execute_stage_md.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/execute_stage_md.sv
// execute_stage_md: pipeline execute stage with an iterative multiply/divide unit.
//   Inputs : decoded E-stage controls, forwarding selects, register operands,
//            PC/immediate, W-stage result for forwarding, hazard-unit flush.
//   Outputs: branch/jump redirect (PCSrcE, PC_TargetE), ALU zero flag,
//            stall request (BusyE) and the registered E/M pipeline register.
//   The MD unit is a 3-state FSM (IDLE/RUN/DONE). It performs one shift-add
//   (MUL) or restoring-subtract (DIVU/REMU) step per RUN cycle.
module execute_stage_md #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3,
  parameter int MD_EN  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RegwriteE,
  input  logic              MemwriteE,
  input  logic              ALUSrcE,
  input  logic              JumpE,
  input  logic              BranchE,
  input  logic              FlushE,
  input  logic [1:0]        ResultSrcE,
  input  logic [1:0]        ForwardA_E,
  input  logic [1:0]        ForwardB_E,
  input  logic [1:0]        MdOpE,
  input  logic [3:0]        ALUControlE,
  input  logic [2:0]        funct3E,
  input  logic [REG_AW-1:0] RdE,
  input  logic [DATA_W-1:0] RD1E,
  input  logic [DATA_W-1:0] RD2E,
  input  logic [DATA_W-1:0] PCE,
  input  logic [DATA_W-1:0] ImmExtE,
  input  logic [DATA_W-1:0] PcPlus4E,
  input  logic [DATA_W-1:0] ResultW,
  output logic              PCSrcE,
  output logic              ZeroE,
  output logic              BusyE,
  output logic [DATA_W-1:0] PC_TargetE,
  output logic              RegwriteM,
  output logic              MemwriteM,
  output logic [1:0]        ResultSrcM,
  output logic [REG_AW-1:0] RdM,
  output logic [DATA_W-1:0] ALUResultM,
  output logic [DATA_W-1:0] WriteDataM,
  output logic [DATA_W-1:0] PcPlus4M
);

  localparam int SHW   = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd2} md_state_e;

  md_state_e            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [1:0]           op_q, op_d;
  logic [DATA_W-1:0]    a_q, a_d, b_q, b_d, acc_q, acc_d;
  logic                 regwrite_m_q, regwrite_m_d, memwrite_m_q, memwrite_m_d;
  logic [1:0]           result_src_m_q, result_src_m_d;
  logic [REG_AW-1:0]    rd_m_q, rd_m_d;
  logic [DATA_W-1:0]    alu_result_m_q, alu_result_m_d;
  logic [DATA_W-1:0]    write_data_m_q, write_data_m_d, pc_plus4_m_q, pc_plus4_m_d;

  logic [DATA_W-1:0]    src_a, src_b_fwd, src_b, alu_result, md_result, ex_result;
  logic [SHW-1:0]       shamt;
  logic [1:0]           md_op_eff;
  logic                 md_issue, md_done, branch_cond;
  logic [DATA_W:0]      rem_shift;
  logic [DATA_W-1:0]    rem_sub;
  logic                 rem_ge;

  assign md_op_eff  = (MD_EN != 0) ? MdOpE : 2'b00;
  assign shamt      = src_b[SHW-1:0];
  assign PC_TargetE = PCE + ImmExtE;
  assign ZeroE      = (alu_result == '0);

  // Operand forwarding; ALUResultM feeds back from the E/M register.
  always_comb begin
    src_a     = RD1E;
    src_b_fwd = RD2E;
    case (ForwardA_E)
      2'b01:   src_a = ResultW;
      2'b10:   src_a = alu_result_m_q;
      default: src_a = RD1E;
    endcase
    case (ForwardB_E)
      2'b01:   src_b_fwd = ResultW;
      2'b10:   src_b_fwd = alu_result_m_q;
      default: src_b_fwd = RD2E;
    endcase
    if (ALUSrcE) begin
      src_b = ImmExtE;
    end else begin
      src_b = src_b_fwd;
    end
  end

  // Single-cycle ALU.
  always_comb begin
    alu_result = '0;
    case (ALUControlE)
      4'd0:    alu_result = src_a + src_b;
      4'd1:    alu_result = src_a - src_b;
      4'd2:    alu_result = src_a & src_b;
      4'd3:    alu_result = src_a | src_b;
      4'd4:    alu_result = src_a ^ src_b;
      4'd5:    alu_result = {{(DATA_W-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      4'd6:    alu_result = {{(DATA_W-1){1'b0}}, (src_a < src_b)};
      4'd7:    alu_result = src_a << shamt;
      4'd8:    alu_result = src_a >> shamt;
      4'd9:    alu_result = $unsigned($signed(src_a) >>> shamt);
      default: alu_result = '0;
    endcase
  end

  // Branch condition and redirect; a stalled stage never redirects.
  always_comb begin
    branch_cond = 1'b0;
    case (funct3E)
      3'b000:  branch_cond = ZeroE;
      3'b001:  branch_cond = ~ZeroE;
      3'b100:  branch_cond = ($signed(src_a) < $signed(src_b));
      3'b101:  branch_cond = ($signed(src_a) >= $signed(src_b));
      3'b110:  branch_cond = (src_a < src_b);
      3'b111:  branch_cond = (src_a >= src_b);
      default: branch_cond = 1'b0;
    endcase
    PCSrcE = (JumpE | (BranchE & branch_cond)) & ~BusyE;
  end

  // MD FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // MD FSM next-state logic; a flush aborts from any state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (md_issue) state_d = ST_RUN;
        else          state_d = ST_IDLE;
      end
      ST_RUN: begin
        if (FlushE)                        state_d = ST_IDLE;
        else if (cnt_q == CNT_W'(1))       state_d = ST_DONE;
        else                               state_d = ST_RUN;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // MD FSM outputs; BusyE is gated by reset so it reads 0 while rst is low.
  always_comb begin
    md_issue = rst & (state_q == ST_IDLE) & (md_op_eff != 2'b00) & ~FlushE;
    md_done  = (state_q == ST_DONE);
    BusyE    = md_issue | (rst & (state_q == ST_RUN));
  end

  // One restoring-division step: remainder shifts in the next dividend bit.
  assign rem_shift = {acc_q, a_q[DATA_W-1]};
  assign rem_ge    = (rem_shift >= {1'b0, b_q});
  assign rem_sub   = rem_shift[DATA_W-1:0] - b_q;

  // MD datapath next values: a_q is multiplicand or dividend/quotient,
  // b_q is multiplier or divisor, acc_q is product or remainder.
  always_comb begin
    cnt_d = cnt_q;
    op_d  = op_q;
    a_d   = a_q;
    b_d   = b_q;
    acc_d = acc_q;
    if (md_issue) begin
      cnt_d = CNT_W'(DATA_W);
      op_d  = md_op_eff;
      a_d   = src_a;
      b_d   = src_b_fwd;
      acc_d = '0;
    end else if ((state_q == ST_RUN) && !FlushE) begin
      cnt_d = cnt_q - CNT_W'(1);
      if (op_q == 2'b01) begin
        if (b_q[0]) acc_d = acc_q + a_q;
        else        acc_d = acc_q;
        a_d = {a_q[DATA_W-2:0], 1'b0};
        b_d = {1'b0, b_q[DATA_W-1:1]};
      end else begin
        a_d = {a_q[DATA_W-2:0], rem_ge};
        if (rem_ge) acc_d = rem_sub;
        else        acc_d = rem_shift[DATA_W-1:0];
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // MD datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      op_q  <= 2'b00;
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      op_q  <= op_d;
      a_q   <= a_d;
      b_q   <= b_d;
      acc_q <= acc_d;
    end
  end

  // Result select: the finished MD result replaces the ALU result in DONE.
  always_comb begin
    case (op_q)
      2'b01:   md_result = acc_q;
      2'b10:   md_result = a_q;
      2'b11:   md_result = acc_q;
      default: md_result = '0;
    endcase
    if (md_done) ex_result = md_result;
    else         ex_result = alu_result;
  end

  // E/M next values: a bubble while stalled or flushed.
  always_comb begin
    if (BusyE || FlushE) begin
      regwrite_m_d   = 1'b0;
      memwrite_m_d   = 1'b0;
      result_src_m_d = 2'b00;
      rd_m_d         = '0;
      alu_result_m_d = '0;
      write_data_m_d = '0;
      pc_plus4_m_d   = '0;
    end else begin
      regwrite_m_d   = RegwriteE;
      memwrite_m_d   = MemwriteE;
      result_src_m_d = ResultSrcE;
      rd_m_d         = RdE;
      alu_result_m_d = ex_result;
      write_data_m_d = src_b_fwd;
      pc_plus4_m_d   = PcPlus4E;
    end
  end

  // E/M pipeline register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      regwrite_m_q   <= 1'b0;
      memwrite_m_q   <= 1'b0;
      result_src_m_q <= 2'b00;
      rd_m_q         <= '0;
      alu_result_m_q <= '0;
      write_data_m_q <= '0;
      pc_plus4_m_q   <= '0;
    end else begin
      regwrite_m_q   <= regwrite_m_d;
      memwrite_m_q   <= memwrite_m_d;
      result_src_m_q <= result_src_m_d;
      rd_m_q         <= rd_m_d;
      alu_result_m_q <= alu_result_m_d;
      write_data_m_q <= write_data_m_d;
      pc_plus4_m_q   <= pc_plus4_m_d;
    end
  end

  assign RegwriteM  = regwrite_m_q;
  assign MemwriteM  = memwrite_m_q;
  assign ResultSrcM = result_src_m_q;
  assign RdM        = rd_m_q;
  assign ALUResultM = alu_result_m_q;
  assign WriteDataM = write_data_m_q;
  assign PcPlus4M   = pc_plus4_m_q;

endmodule

// File: tb/tb_execute_stage_md.sv
module tb_execute_stage_md;

  localparam int DW = 16;
  localparam int AW = 3;

  logic          clk, rst;
  logic          RegwriteE, MemwriteE, ALUSrcE, JumpE, BranchE, FlushE;
  logic [1:0]    ResultSrcE, ForwardA_E, ForwardB_E, MdOpE;
  logic [3:0]    ALUControlE;
  logic [2:0]    funct3E;
  logic [AW-1:0] RdE;
  logic [DW-1:0] RD1E, RD2E, PCE, ImmExtE, PcPlus4E, ResultW;
  logic          PCSrcE, ZeroE, BusyE;
  logic [DW-1:0] PC_TargetE;
  logic          RegwriteM, MemwriteM;
  logic [1:0]    ResultSrcM;
  logic [AW-1:0] RdM;
  logic [DW-1:0] ALUResultM, WriteDataM, PcPlus4M;

  int checks = 0;
  int failures = 0;

  execute_stage_md #(.DATA_W(DW), .REG_AW(AW), .MD_EN(1)) dut (
    .clk(clk), .rst(rst),
    .RegwriteE(RegwriteE), .MemwriteE(MemwriteE), .ALUSrcE(ALUSrcE),
    .JumpE(JumpE), .BranchE(BranchE), .FlushE(FlushE),
    .ResultSrcE(ResultSrcE), .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E),
    .MdOpE(MdOpE), .ALUControlE(ALUControlE), .funct3E(funct3E), .RdE(RdE),
    .RD1E(RD1E), .RD2E(RD2E), .PCE(PCE), .ImmExtE(ImmExtE),
    .PcPlus4E(PcPlus4E), .ResultW(ResultW),
    .PCSrcE(PCSrcE), .ZeroE(ZeroE), .BusyE(BusyE), .PC_TargetE(PC_TargetE),
    .RegwriteM(RegwriteM), .MemwriteM(MemwriteM), .ResultSrcM(ResultSrcM),
    .RdM(RdM), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .PcPlus4M(PcPlus4M)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [3:0]  ctl;
    logic        src;
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic [15:0] rd1;
    logic [15:0] rd2;
    logic [15:0] imm;
    logic [15:0] resw;
    logic [15:0] pce;
    logic        br;
    logic        jmp;
    logic [2:0]  f3;
    logic [15:0] exp_alu;
    logic [15:0] exp_wd;
    logic        exp_zero;
    logic        exp_pcsrc;
    logic [15:0] exp_tgt;
  } vec_t;

  vec_t vecs[18];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic drive_defaults();
    RegwriteE = 1'b1; MemwriteE = 1'b0; ALUSrcE = 1'b0; JumpE = 1'b0;
    BranchE = 1'b0; FlushE = 1'b0; ResultSrcE = 2'b01; ForwardA_E = 2'b00;
    ForwardB_E = 2'b00; MdOpE = 2'b00; ALUControlE = 4'd0; funct3E = 3'b000;
    RdE = 3'd5; RD1E = 16'h0000; RD2E = 16'h0000; PCE = 16'h0000;
    ImmExtE = 16'h0000; PcPlus4E = 16'h0104; ResultW = 16'h0000;
  endtask

  // Issue one MD op from the drive point and follow it to its result edge.
  task automatic md_run(input string nm, input logic [1:0] op,
                        input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] exp);
    int  busy_n;
    bit  stall_ok;
    busy_n = 0;
    stall_ok = 1'b1;
    drive_defaults();
    MdOpE = op; RD1E = a; RD2E = b; RdE = 3'd6; JumpE = 1'b1;
    for (int e = 1; e <= DW + 2; e++) begin
      @(negedge clk);
      if (BusyE) begin
        busy_n++;
        if (PCSrcE) stall_ok = 1'b0;
      end
      @(posedge clk); #1;
      if (e == 1) begin
        RD1E = 16'hFFFF; RD2E = 16'hFFFF;
      end
      if (e < DW + 2 && (RegwriteM || RdM != 3'd0)) stall_ok = 1'b0;
    end
    chk({nm, "_busy_cycles"}, busy_n, DW + 1);
    chk({nm, "_bubbles"}, {31'd0, stall_ok}, 32'd1);
    chk({nm, "_result"}, {16'd0, ALUResultM}, {16'd0, exp});
    chk({nm, "_rd"}, {29'd0, RdM}, 32'd6);
    MdOpE = 2'b00; JumpE = 1'b0;
    @(negedge clk);
    chk({nm, "_idle_busy"}, {31'd0, BusyE}, 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    vecs[0]  = '{4'd0, 1'b0, 2'b00, 2'b00, 16'h0005, 16'h0003, 16'h0000, 16'h0000, 16'h0100, 1'b0, 1'b0, 3'b000, 16'h0008, 16'h0003, 1'b0, 1'b0, 16'h0100};
    vecs[1]  = '{4'd0, 1'b1, 2'b00, 2'b00, 16'h1200, 16'h0000, 16'h0034, 16'h0000, 16'h0000, 1'b0, 1'b0, 3'b000, 16'h1234, 16'h0000, 1'b0, 1'b0, 16'h0034};
    vecs[2]  = '{4'd1, 1'b0, 2'b10, 2'b00, 16'h0000, 16'h0001, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 3'b000, 16'h1233, 16'h0001, 1'b0, 1'b0, 16'h0000};
    vecs[3]  = '{4'd0, 1'b0, 2'b00, 2'b01, 16'h0001, 16'hFFFF, 16'h0000, 16'h0010, 16'h0000, 1'b0, 1'b0, 3'b000, 16'h0011, 16'h0010, 1'b0, 1'b0, 16'h0000};
    vecs[4]  = '{4'd2, 1'b0, 2'b00, 2'b00, 16'hF0F0, 16'h0FF0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 3'b000, 16'h00F0, 16'h0FF0, 1'b0, 1'b0, 16'h0000};
    vecs[5]  = '{4'd3, 1'b0, 2'b00, 2'b00, 16'hF0F0, 16'h0F0F, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 3'b000, 16'hFFFF, 16'h0F0F, 1'b0, 1'b0, 16'h0000};
    vecs[6]  = '{4'd4, 1'b0, 2'b00, 2'b00, 16'hAAAA, 16'hAAAA, 16'h0010, 16'h0000, 16'h0200, 1'b1, 1'b0, 3'b000, 16'h0000, 16'hAAAA, 1'b1, 1'b1, 16'h0210};
    vecs[7]  = '{4'd5, 1'b0, 2'b00, 2'b00, 16'h8000, 16'h0001, 16'h0020, 16'h0000, 16'hFFF0, 1'b1, 1'b0, 3'b100, 16'h0001, 16'h0001, 1'b0, 1'b1, 16'h0010};
    vecs[8]  = '{4'd6, 1'b0, 2'b00, 2'b00, 16'h8000, 16'h0001, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0, 3'b110, 16'h0000, 16'h0001, 1'b1, 1'b0, 16'h0000};
    vecs[9]  = '{4'd7, 1'b0, 2'b00, 2'b00, 16'h0001, 16'h0014, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 3'b000, 16'h0010, 16'h0014, 1'b0, 1'b0, 16'h0000};
    vecs[10] = '{4'd8, 1'b0, 2'b00, 2'b00, 16'h8000, 16'h000F, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 3'b000, 16'h0001, 16'h000F, 1'b0, 1'b0, 16'h0000};
    vecs[11] = '{4'd9, 1'b0, 2'b00, 2'b00, 16'h8000, 16'h0004, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 3'b000, 16'hF800, 16'h0004, 1'b0, 1'b0, 16'h0000};
    vecs[12] = '{4'd10, 1'b0, 2'b00, 2'b00, 16'h1234, 16'h5678, 16'h0004, 16'h0000, 16'h0300, 1'b0, 1'b1, 3'b000, 16'h0000, 16'h5678, 1'b1, 1'b1, 16'h0304};
    vecs[13] = '{4'd0, 1'b0, 2'b00, 2'b00, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0, 3'b001, 16'h0000, 16'h0001, 1'b1, 1'b0, 16'h0000};
    vecs[14] = '{4'd1, 1'b0, 2'b00, 2'b00, 16'h0003, 16'h0005, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0, 3'b101, 16'hFFFE, 16'h0005, 1'b0, 1'b0, 16'h0000};
    vecs[15] = '{4'd1, 1'b0, 2'b00, 2'b00, 16'h0005, 16'h0003, 16'h0008, 16'h0000, 16'h0040, 1'b1, 1'b0, 3'b111, 16'h0002, 16'h0003, 1'b0, 1'b1, 16'h0048};
    vecs[16] = '{4'd0, 1'b0, 2'b00, 2'b00, 16'h0001, 16'h0001, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0, 3'b010, 16'h0002, 16'h0001, 1'b0, 1'b0, 16'h0000};
    vecs[17] = '{4'd1, 1'b0, 2'b00, 2'b00, 16'h0007, 16'h0003, 16'h0FF0, 16'h0000, 16'h1000, 1'b1, 1'b0, 3'b001, 16'h0004, 16'h0003, 1'b0, 1'b1, 16'h1FF0};

    // Reset state, with an MD op requested to show BusyE stays low.
    rst = 1'b1;
    drive_defaults();
    MdOpE = 2'b01; RD1E = 16'h1111; RD2E = 16'h2222;
    #1 rst = 1'b0;
    #1;
    chk("rst_regwrite", {31'd0, RegwriteM}, 32'd0);
    chk("rst_alu", {16'd0, ALUResultM}, 32'd0);
    chk("rst_busy", {31'd0, BusyE}, 32'd0);
    chk("rst_pcplus4", {16'd0, PcPlus4M}, 32'd0);
    MdOpE = 2'b00;
    #1 rst = 1'b1;
    @(posedge clk); #1;

    // Table-driven ALU / forwarding / branch vectors.
    for (int i = 0; i < 18; i++) begin
      drive_defaults();
      ALUControlE = vecs[i].ctl; ALUSrcE = vecs[i].src;
      ForwardA_E = vecs[i].fa; ForwardB_E = vecs[i].fb;
      RD1E = vecs[i].rd1; RD2E = vecs[i].rd2; ImmExtE = vecs[i].imm;
      ResultW = vecs[i].resw; PCE = vecs[i].pce; BranchE = vecs[i].br;
      JumpE = vecs[i].jmp; funct3E = vecs[i].f3;
      @(negedge clk);
      chk($sformatf("v%0d_zero", i), {31'd0, ZeroE}, {31'd0, vecs[i].exp_zero});
      chk($sformatf("v%0d_pcsrc", i), {31'd0, PCSrcE}, {31'd0, vecs[i].exp_pcsrc});
      chk($sformatf("v%0d_target", i), {16'd0, PC_TargetE}, {16'd0, vecs[i].exp_tgt});
      chk($sformatf("v%0d_busy", i), {31'd0, BusyE}, 32'd0);
      @(posedge clk); #1;
      chk($sformatf("v%0d_alu", i), {16'd0, ALUResultM}, {16'd0, vecs[i].exp_alu});
      chk($sformatf("v%0d_wdata", i), {16'd0, WriteDataM}, {16'd0, vecs[i].exp_wd});
      chk($sformatf("v%0d_ctrl", i), {26'd0, RegwriteM, MemwriteM, ResultSrcM, RdM[1:0]},
          {26'd0, 1'b1, 1'b0, 2'b01, 2'b01});
      chk($sformatf("v%0d_rdpc", i), {13'd0, RdM, PcPlus4M}, {13'd0, 3'd5, 16'h0104});
    end

    // Multiply / divide sequences.
    md_run("mul", 2'b01, 16'h0102, 16'h0100, 16'h0200);
    md_run("mul2", 2'b01, 16'h00FF, 16'h0101, 16'hFFFF);
    md_run("divu0", 2'b10, 16'h0007, 16'h0000, 16'hFFFF);
    md_run("remu0", 2'b11, 16'h0007, 16'h0000, 16'h0007);
    md_run("divu", 2'b10, 16'd100, 16'd7, 16'd14);
    md_run("remu", 2'b11, 16'd100, 16'd7, 16'd2);

    // Flush in IDLE blocks issue and bubbles E/M.
    drive_defaults();
    MdOpE = 2'b01; RD1E = 16'h0005; RD2E = 16'h0003; FlushE = 1'b1;
    @(negedge clk);
    chk("flush_idle_busy", {31'd0, BusyE}, 32'd0);
    @(posedge clk); #1;
    chk("flush_idle_bubble", {15'd0, RegwriteM, ALUResultM}, 32'd0);
    FlushE = 1'b0; MdOpE = 2'b00;
    @(negedge clk);
    chk("flush_idle_noissue", {31'd0, BusyE}, 32'd0);
    @(posedge clk); #1;
    chk("flush_idle_next", {15'd0, RegwriteM, ALUResultM}, {15'd0, 1'b1, 16'h0008});

    // Flush mid-RUN aborts back to IDLE.
    drive_defaults();
    MdOpE = 2'b01; RD1E = 16'h0003; RD2E = 16'h0004;
    repeat (5) @(posedge clk);
    #1 FlushE = 1'b1;
    @(negedge clk);
    chk("flush_run_busy", {31'd0, BusyE}, 32'd1);
    @(posedge clk); #1;
    chk("flush_run_bubble", {31'd0, RegwriteM}, 32'd0);
    FlushE = 1'b0; MdOpE = 2'b00; RD1E = 16'h0005; RD2E = 16'h0003;
    @(negedge clk);
    chk("flush_run_idle", {31'd0, BusyE}, 32'd0);
    @(posedge clk); #1;
    chk("flush_run_next", {15'd0, RegwriteM, ALUResultM}, {15'd0, 1'b1, 16'h0008});

    // Reset mid-RUN aborts without writing a result.
    drive_defaults();
    MdOpE = 2'b01; RD1E = 16'h0102; RD2E = 16'h0100;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_run_busy", {31'd0, BusyE}, 32'd0);
    chk("rst_run_m", {15'd0, RegwriteM, ALUResultM}, 32'd0);
    MdOpE = 2'b00; RD1E = 16'h0005; RD2E = 16'h0003;
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_run_idle", {31'd0, BusyE}, 32'd0);
    @(posedge clk); #1;
    chk("rst_run_next", {15'd0, RegwriteM, ALUResultM}, {15'd0, 1'b1, 16'h0008});

    // Asynchronous reset clears a populated E/M register between edges.
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("async_rst_ctrl", {27'd0, RegwriteM, MemwriteM, ResultSrcM, RdM[0]}, 32'd0);
    chk("async_rst_data", {ALUResultM, WriteDataM}, 32'd0);
    chk("async_rst_rdpc", {13'd0, RdM, PcPlus4M}, 32'd0);
    #1 rst = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
